// File: rtl/sr_run_ctrl_pkg.sv
// Shared opcodes, response codes and state encodings for the sr_cpu run-control sequencer.
package sr_run_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_HALT     = 3'd1,
    OP_RUN      = 3'd2,
    OP_STEP     = 3'd3,
    OP_RUN_N    = 3'd4,
    OP_READ_REG = 3'd5,
    OP_SET_BP   = 3'd6,
    OP_CLR_BP   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    RSP_OK  = 2'd0,
    RSP_BP  = 2'd1,
    RSP_REJ = 2'd2
  } rsp_e;

  typedef enum logic [1:0] {
    ST_HALTED  = 2'd0,
    ST_RUN     = 2'd1,
    ST_RUN_N   = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/sr_run_ctrl_if.sv
// Host command/response channel of the run-control sequencer (valid/ready both ways).
interface sr_run_ctrl_if #(
  parameter int PC_W = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [PC_W-1:0] cmd_arg;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_code;
  logic [PC_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_code, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
    output cmd_ready, rsp_valid, rsp_code, rsp_data
  );
endinterface

// File: rtl/sr_run_ctrl_rsp_buf.sv
// Single-entry response holding register; a loaded response stays put until the host takes it.
module sr_run_ctrl_rsp_buf #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [1:0]      loadCode,
  input  logic [PC_W-1:0] loadData,
  input  logic            ready,
  output logic            valid,
  output logic [1:0]      code,
  output logic [PC_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      code  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      code  <= loadCode;
      data  <= loadData;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sr_run_ctrl.sv
// Run-control sequencer for sr_cpu: gates clkEnable, runs N-step bursts, breakpoints and register reads.
module sr_run_ctrl
  import sr_run_ctrl_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_run_ctrl_if.slave     host,
  input  logic [PC_W-1:0]  cpu_pc,
  output logic             cpu_clk_en,
  output logic [4:0]       dbg_reg_addr,
  input  logic [31:0]      dbg_reg_data,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e            state, nextState;
  op_e               op;
  logic              cmdFire, canLoad, running, expire, haltCmd, bpStop;
  logic [CNT_W-1:0]  remain;
  logic [PC_W-1:0]   bpAddr;
  logic              bpEn, armed, bpHitQ;
  logic              pendValid;
  rsp_e              pendCode;
  logic [SET_W-1:0]  settleCnt;
  logic              rspLoad;
  rsp_e              rspCodeIn;
  logic [PC_W-1:0]   rspDataIn;

  assign op      = op_e'(host.cmd_op);
  assign canLoad = !host.rsp_valid || host.rsp_ready;
  assign cmdFire = host.cmd_valid && host.cmd_ready;
  assign running = (state == ST_RUN) || (state == ST_RUN_N);
  // RUN_N spends one extra disabled cycle at count zero so the reported pc includes the last step.
  assign expire  = (state == ST_RUN_N) && (remain == '0);
  assign haltCmd = cmdFire && (op == OP_HALT);
  assign bpStop  = running && !expire && bpEn && armed && (cpu_pc == bpAddr);
  assign bp_hit  = bpHitQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HALTED;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_HALTED: begin
        if (cmdFire) begin
          if (op == OP_RUN) nextState = ST_RUN;
          else if (op == OP_STEP || (op == OP_RUN_N && host.cmd_arg != '0)) nextState = ST_RUN_N;
          else if (op == OP_READ_REG) nextState = ST_RD_WAIT;
        end
      end
      ST_RUN, ST_RUN_N: if (haltCmd || bpStop || expire) nextState = ST_HALTED;
      ST_RD_WAIT:       if (settleCnt == '0) nextState = ST_HALTED;
      default:          nextState = ST_HALTED;
    endcase
  end

  always_comb begin
    host.cmd_ready = canLoad && (state != ST_RD_WAIT) && !pendValid;
    cpu_clk_en     = running && !expire && !bpStop;
    halted         = (state == ST_HALTED);
  end

  // Stop responses from a run are deferred into HALTED so they carry the settled pc.
  always_comb begin
    rspLoad   = 1'b0;
    rspCodeIn = RSP_OK;
    rspDataIn = '0;
    if (state == ST_RD_WAIT) begin
      rspLoad   = (settleCnt == '0);
      rspDataIn = PC_W'(dbg_reg_data);
    end else if (pendValid) begin
      rspLoad   = canLoad;
      rspCodeIn = pendCode;
      rspDataIn = cpu_pc;
    end else if (cmdFire) begin
      case (op)
        OP_NOP, OP_SET_BP, OP_CLR_BP: rspLoad = 1'b1;
        OP_HALT: begin
          rspLoad   = !running;
          rspDataIn = cpu_pc;
        end
        OP_RUN: begin
          rspLoad   = 1'b1;
          rspCodeIn = running ? RSP_REJ : RSP_OK;
        end
        OP_STEP, OP_READ_REG: begin
          rspLoad   = running;
          rspCodeIn = RSP_REJ;
        end
        OP_RUN_N: begin
          rspLoad   = running || (host.cmd_arg == '0);
          rspCodeIn = running ? RSP_REJ : RSP_OK;
          rspDataIn = running ? '0 : cpu_pc;
        end
        default: rspLoad = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt    <= '0;
      bpHitQ       <= 1'b0;
      bpEn         <= 1'b0;
      bpAddr       <= '0;
      armed        <= 1'b0;
      remain       <= '0;
      dbg_reg_addr <= '0;
      settleCnt    <= '0;
      pendValid    <= 1'b0;
      pendCode     <= RSP_OK;
    end else begin
      if (cpu_clk_en) instr_cnt <= instr_cnt + CNT_W'(1);
      bpHitQ <= bpStop;

      if (cmdFire && op == OP_SET_BP) begin
        bpEn   <= 1'b1;
        bpAddr <= host.cmd_arg;
      end else if (cmdFire && op == OP_CLR_BP) begin
        bpEn <= 1'b0;
      end

      // Disarm on entry so resuming while parked on the breakpoint executes that instruction.
      if (state == ST_HALTED && (nextState == ST_RUN || nextState == ST_RUN_N)) armed <= 1'b0;
      else if (cpu_clk_en)                                                    armed <= 1'b1;

      if (state == ST_HALTED && cmdFire && op == OP_STEP)       remain <= CNT_W'(1);
      else if (state == ST_HALTED && cmdFire && op == OP_RUN_N) remain <= CNT_W'(host.cmd_arg);
      else if (state == ST_RUN_N && cpu_clk_en)                 remain <= remain - CNT_W'(1);

      if (state == ST_HALTED && cmdFire && op == OP_READ_REG) begin
        dbg_reg_addr <= host.cmd_arg[4:0];
        settleCnt    <= SET_W'(SETTLE - 1);
      end else if (state == ST_RD_WAIT && settleCnt != '0) begin
        settleCnt <= settleCnt - SET_W'(1);
      end

      if (running && haltCmd) begin
        pendValid <= 1'b1;
        pendCode  <= RSP_OK;
      end else if (expire) begin
        pendValid <= 1'b1;
        pendCode  <= RSP_OK;
      end else if (state == ST_RUN_N && bpStop) begin
        pendValid <= 1'b1;
        pendCode  <= RSP_BP;
      end else if (pendValid && canLoad) begin
        pendValid <= 1'b0;
      end
    end
  end

  sr_run_ctrl_rsp_buf #(.PC_W(PC_W)) u_rspBuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rspLoad),
    .loadCode (rspCodeIn),
    .loadData (rspDataIn),
    .ready    (host.rsp_ready),
    .valid    (host.rsp_valid),
    .code     (host.rsp_code),
    .data     (host.rsp_data)
  );

endmodule

// File: tb/tb_sr_run_ctrl.sv
// Directed bench for sr_run_ctrl with a tiny CPU stand-in (pc += 4 per enabled cycle, rf[i] = 0xCAFE0000|i).
module tb_sr_run_ctrl;
  import sr_run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpuPc;
  logic        cpuClkEn;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        halted, bpHit;
  logic [31:0] instrCnt;

  int total = 0;
  int bad   = 0;
  int enTotal = 0;
  int bpTotal = 0;
  logic [1:0]  rCode;
  logic [31:0] rData;

  sr_run_ctrl_if #(.PC_W(32)) ifc ();

  sr_run_ctrl #(.PC_W(32), .CNT_W(32), .SETTLE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (ifc),
    .cpu_pc       (cpuPc),
    .cpu_clk_en   (cpuClkEn),
    .dbg_reg_addr (regAddr),
    .dbg_reg_data (regData),
    .halted       (halted),
    .bp_hit       (bpHit),
    .instr_cnt    (instrCnt)
  );

  always #5 clk = ~clk;

  assign regData = 32'hCAFE_0000 | {27'd0, regAddr};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cpuPc <= 32'd0;
    else if (cpuClkEn) cpuPc <= cpuPc + 32'd4;
  end

  always @(posedge clk) begin
    if (cpuClkEn) enTotal <= enTotal + 1;
    if (bpHit)    bpTotal <= bpTotal + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got still_running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic sendCmd(input op_e op, input logic [31:0] arg);
    int n = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_arg   = arg;
    while (!ifc.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!ifc.cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_accept op=%0d got ready=0 want 1", op);
    end
    tick();
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic getRsp();
    bit got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      if (ifc.rsp_valid) begin
        rCode = ifc.rsp_code;
        rData = ifc.rsp_data;
        got   = 1'b1;
      end
      tick();
    end
    if (!got) begin
      total++; bad++;
      rCode = 2'd3;
      rData = 32'hDEAD_DEAD;
      $display("FAIL rsp_timeout got valid=0 want 1");
    end
  endtask

  task automatic test_reset();
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 3'd0;
    ifc.cmd_arg   = 32'd0;
    ifc.rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({cpuClkEn, ifc.cmd_ready, ifc.rsp_valid, ifc.rsp_code, halted, bpHit} !== 7'b0100010) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 0100010",
               {cpuClkEn, ifc.cmd_ready, ifc.rsp_valid, ifc.rsp_code, halted, bpHit});
    end
    total++;
    if (ifc.rsp_data !== 32'd0 || regAddr !== 5'd0 || instrCnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_data got data=%h addr=%0d cnt=%0d want 0 0 0", ifc.rsp_data, regAddr, instrCnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_step();
    int base;
    for (int i = 1; i <= 3; i++) begin
      base = enTotal;
      sendCmd(OP_STEP, 32'd0);
      getRsp();
      total++;
      if (rCode !== 2'd0 || rData !== 32'(4 * i)) begin
        bad++;
        $display("FAIL step%0d_rsp got code=%0d data=%h want code=0 data=%h", i, rCode, rData, 32'(4 * i));
      end
      total++;
      if (enTotal - base !== 1) begin
        bad++;
        $display("FAIL step%0d_en got %0d want 1", i, enTotal - base);
      end
    end
    total++;
    if (instrCnt !== 32'd3) begin
      bad++;
      $display("FAIL step_instr_cnt got %0d want 3", instrCnt);
    end
    base = enTotal;
    sendCmd(OP_RUN_N, 32'd0);
    getRsp();
    total++;
    if (rCode !== 2'd0 || rData !== 32'h0000_000C || enTotal - base !== 0) begin
      bad++;
      $display("FAIL run_n0 got code=%0d data=%h en=%0d want code=0 data=0000000c en=0",
               rCode, rData, enTotal - base);
    end
  endtask

  task automatic test_run_n();
    int base = enTotal;
    sendCmd(OP_RUN_N, 32'd10);
    getRsp();
    total++;
    if (rCode !== 2'd0 || rData !== 32'h0000_0034) begin
      bad++;
      $display("FAIL run_n10_rsp got code=%0d data=%h want code=0 data=00000034", rCode, rData);
    end
    total++;
    if (enTotal - base !== 10 || halted !== 1'b1 || instrCnt !== 32'd13) begin
      bad++;
      $display("FAIL run_n10_state got en=%0d halted=%b cnt=%0d want en=10 halted=1 cnt=13",
               enTotal - base, halted, instrCnt);
    end
  endtask

  task automatic test_breakpoint();
    int base, bpBase;
    logic [31:0] savedPc;
    doReset();
    sendCmd(OP_SET_BP, 32'h10);
    getRsp();
    total++;
    if (rCode !== 2'd0 || rData !== 32'd0) begin
      bad++;
      $display("FAIL set_bp_rsp got code=%0d data=%h want code=0 data=0", rCode, rData);
    end
    base = enTotal;
    bpBase = bpTotal;
    sendCmd(OP_RUN, 32'd0);
    getRsp();
    total++;
    if (rCode !== 2'd0 || rData !== 32'd0) begin
      bad++;
      $display("FAIL run_ack got code=%0d data=%h want code=0 data=0", rCode, rData);
    end
    for (int n = 0; n < 50 && !halted; n++) tick();
    total++;
    if (halted !== 1'b1 || bpHit !== 1'b1 || cpuPc !== 32'h10 || enTotal - base !== 4) begin
      bad++;
      $display("FAIL bp_stop got halted=%b hit=%b pc=%h en=%0d want halted=1 hit=1 pc=00000010 en=4",
               halted, bpHit, cpuPc, enTotal - base);
    end
    tick();
    total++;
    if (bpHit !== 1'b0 || bpTotal - bpBase !== 1 || ifc.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_pulse got hit=%b hits=%0d rsp_valid=%b want hit=0 hits=1 rsp_valid=0",
               bpHit, bpTotal - bpBase, ifc.rsp_valid);
    end
    sendCmd(OP_RUN, 32'd0);
    getRsp();
    for (int n = 0; n < 4; n++) tick();
    total++;
    if (halted !== 1'b0 || cpuPc <= 32'h10 || rCode !== 2'd0) begin
      bad++;
      $display("FAIL bp_resume got halted=%b pc=%h code=%0d want halted=0 pc>00000010 code=0",
               halted, cpuPc, rCode);
    end
    sendCmd(OP_HALT, 32'd0);
    getRsp();
    savedPc = cpuPc;
    total++;
    if (rCode !== 2'd0 || rData !== cpuPc || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_rsp got code=%0d data=%h halted=%b want code=0 data=%h halted=1",
               rCode, rData, halted, cpuPc);
    end
    for (int n = 0; n < 3; n++) tick();
    total++;
    if (cpuPc !== savedPc) begin
      bad++;
      $display("FAIL halt_hold got pc=%h want %h", cpuPc, savedPc);
    end
  endtask

  task automatic test_run_n_bp();
    int base, bpBase;
    doReset();
    sendCmd(OP_SET_BP, 32'h08);
    getRsp();
    base = enTotal;
    bpBase = bpTotal;
    sendCmd(OP_RUN_N, 32'd100);
    getRsp();
    total++;
    if (rCode !== 2'd1 || rData !== 32'h08) begin
      bad++;
      $display("FAIL run_n_bp_rsp got code=%0d data=%h want code=1 data=00000008", rCode, rData);
    end
    total++;
    if (enTotal - base !== 2 || bpTotal - bpBase !== 1 || halted !== 1'b1) begin
      bad++;
      $display("FAIL run_n_bp_state got en=%0d hits=%0d halted=%b want en=2 hits=1 halted=1",
               enTotal - base, bpTotal - bpBase, halted);
    end
  endtask

  task automatic test_read_reg();
    sendCmd(OP_CLR_BP, 32'd0);
    getRsp();
    sendCmd(OP_RUN, 32'd0);
    getRsp();
    sendCmd(OP_READ_REG, 32'd10);
    getRsp();
    total++;
    if (rCode !== 2'd2 || rData !== 32'd0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL read_running got code=%0d data=%h halted=%b want code=2 data=0 halted=0",
               rCode, rData, halted);
    end
    sendCmd(OP_HALT, 32'd0);
    getRsp();
    sendCmd(OP_READ_REG, 32'd10);
    getRsp();
    total++;
    if (rCode !== 2'd0 || rData !== 32'hCAFE_000A || regAddr !== 5'd10) begin
      bad++;
      $display("FAIL read_halted got code=%0d data=%h addr=%0d want code=0 data=cafe000a addr=10",
               rCode, rData, regAddr);
    end
  endtask

  task automatic test_back_pressure();
    doReset();
    sendCmd(OP_STEP, 32'd0);
    getRsp();
    ifc.rsp_ready = 1'b0;
    sendCmd(OP_HALT, 32'd0);
    total++;
    if ({ifc.rsp_valid, ifc.cmd_ready} !== 2'b10 || ifc.rsp_code !== 2'd0 || ifc.rsp_data !== 32'd4) begin
      bad++;
      $display("FAIL stall_first got valid=%b ready=%b code=%0d data=%h want valid=1 ready=0 code=0 data=00000004",
               ifc.rsp_valid, ifc.cmd_ready, ifc.rsp_code, ifc.rsp_data);
    end
    for (int n = 0; n < 3; n++) tick();
    total++;
    if ({ifc.rsp_valid, ifc.cmd_ready} !== 2'b10 || ifc.rsp_code !== 2'd0 || ifc.rsp_data !== 32'd4) begin
      bad++;
      $display("FAIL stall_hold got valid=%b ready=%b code=%0d data=%h want valid=1 ready=0 code=0 data=00000004",
               ifc.rsp_valid, ifc.cmd_ready, ifc.rsp_code, ifc.rsp_data);
    end
    ifc.rsp_ready = 1'b1;
    tick();
    total++;
    if ({ifc.rsp_valid, ifc.cmd_ready} !== 2'b01) begin
      bad++;
      $display("FAIL stall_release got valid=%b ready=%b want valid=0 ready=1", ifc.rsp_valid, ifc.cmd_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    sendCmd(OP_RUN_N, 32'd100);
    for (int n = 0; n < 3; n++) tick();
    total++;
    if (cpuClkEn !== 1'b1) begin
      bad++;
      $display("FAIL mid_run_en got %b want 1", cpuClkEn);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cpuClkEn, ifc.cmd_ready, ifc.rsp_valid, ifc.rsp_code, halted, bpHit} !== 7'b0100010) begin
      bad++;
      $display("FAIL mid_reset_ctrl got %b want 0100010",
               {cpuClkEn, ifc.cmd_ready, ifc.rsp_valid, ifc.rsp_code, halted, bpHit});
    end
    total++;
    if (instrCnt !== 32'd0 || regAddr !== 5'd0 || ifc.rsp_data !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset_data got cnt=%0d addr=%0d data=%h want 0 0 0", instrCnt, regAddr, ifc.rsp_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (cpuClkEn !== 1'b0 || halted !== 1'b1) begin
      bad++;
      $display("FAIL post_reset got en=%b halted=%b want en=0 halted=1", cpuClkEn, halted);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_n();
    test_breakpoint();
    test_run_n_bp();
    test_read_reg();
    test_back_pressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
